// File: rtl/flag_vector_arbiter.sv
// Round-robin arbitrated single-bit writes into a shared flag vector, plus a clear-all sweep.
// Grant, error and flag update are all registered at the edge that samples the request.
// Requesters hold req until granted; req is ignored while the clear sweep runs (busy=1).
// Optional feature macro: FLAG_PARITY_EN adds a registered parity output (^flags).
module flag_vector_arbiter #(
   parameter int WIDTH = 6,
   parameter int NREQ  = 3
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NREQ-1:0]                   req,
   input  logic [NREQ*$clog2(WIDTH)-1:0]     req_idx,
   input  logic [NREQ-1:0]                   req_val,
   output logic [NREQ-1:0]                   gnt,
   output logic                              err,
   input  logic                              clr_all,
   output logic                              busy,
`ifdef FLAG_PARITY_EN
   output logic                              parity,
`endif
   output logic [WIDTH-1:0]                  flags
);

   localparam int IDXW = $clog2(WIDTH);
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     rr_ptr;
   logic [IDXW-1:0]   sweep_idx;
   logic [NREQ-1:0]   eff_req;
   logic              win_vld;
   logic [PW-1:0]     win;
   logic [IDXW-1:0]   win_idx;
   logic              grant_fire;
   logic              idx_bad;
   logic [WIDTH-1:0]  flags_nxt;
   int                cand;

   // A requester still holding req during its own gnt cycle is not re-requesting.
   assign eff_req = req & ~gnt;

   // Round-robin search from rr_ptr; descending loop so the nearest candidate wins.
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      cand    = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = (int'(rr_ptr) + k) % NREQ;
         if (eff_req[cand]) begin
            win_vld = 1'b1;
            win     = PW'(cand);
         end
      end
   end

   assign win_idx    = req_idx[int'(win)*IDXW +: IDXW];
   assign grant_fire = (state == IDLE) && !clr_all && win_vld;
   assign idx_bad    = int'(win_idx) >= WIDTH;

   // Next flag vector: one granted write in IDLE, or one swept bit in CLEAR.
   always_comb begin
      flags_nxt = flags;
      if (grant_fire && !idx_bad)
         flags_nxt[win_idx] = req_val[win];
      if (state == CLEAR)
         flags_nxt[sweep_idx] = 1'b0;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: clr_all starts a sweep; sweep ends after the last bit index.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clr_all) state_nxt = CLEAR;
         CLEAR:   if (int'(sweep_idx) == WIDTH - 1) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM output: busy for the whole sweep.
   always_comb begin
      busy = (state == CLEAR);
   end

   // Datapath registers: flags, grant pulse, error pulse, pointer and sweep index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags     <= '0;
         gnt       <= '0;
         err       <= 1'b0;
         rr_ptr    <= '0;
         sweep_idx <= '0;
      end else begin
         flags <= flags_nxt;
         gnt   <= grant_fire ? (NREQ'(1) << win) : '0;
         err   <= grant_fire && idx_bad;
         if (grant_fire)
            rr_ptr <= PW'((int'(win) + 1) % NREQ);
         if (state == IDLE && clr_all)
            sweep_idx <= '0;
         else if (state == CLEAR)
            sweep_idx <= sweep_idx + 1'b1;
      end
   end

`ifdef FLAG_PARITY_EN
   // Parity tracks the flags register on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity <= 1'b0;
      else        parity <= ^flags_nxt;
   end
`endif

endmodule

// File: tb/tb_flag_vector_arbiter.sv
// Directed bench for flag_vector_arbiter: grants, round-robin, sweep, error, reset.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven there too.
// Requesters drop req in the cycle their grant is observed.
module tb_flag_vector_arbiter;

   localparam int WIDTH = 6;
   localparam int NREQ  = 3;
   localparam int IDXW  = 3;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*IDXW-1:0] req_idx = '0;
   logic [NREQ-1:0]      req_val = '0;
   logic [NREQ-1:0]      gnt;
   logic                 err;
   logic                 clr_all = 1'b0;
   logic                 busy;
   logic [WIDTH-1:0]     flags;
`ifdef FLAG_PARITY_EN
   logic                 parity;
`endif

   int checks = 0;
   int failures = 0;

   flag_vector_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .req_idx (req_idx),
      .req_val (req_val),
      .gnt     (gnt),
      .err     (err),
      .clr_all (clr_all),
      .busy    (busy),
`ifdef FLAG_PARITY_EN
      .parity  (parity),
`endif
      .flags   (flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic [WIDTH-1:0] exp);
      chk(tag, 32'(flags), 32'(exp));
`ifdef FLAG_PARITY_EN
      chk({tag, "_par"}, 32'(parity), 32'(^exp));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      req     = '0;
      clr_all = 1'b0;
      #3;
      rst_n = 1'b1;
      step();
   endtask

   task automatic set_req(input int r, input logic [IDXW-1:0] idx, input logic val);
      req[r]                = 1'b1;
      req_idx[r*IDXW +: IDXW] = idx;
      req_val[r]            = val;
   endtask

   // Single write by requester r; checks grant and resulting flags.
   task automatic do_write(input int r, input logic [IDXW-1:0] idx, input logic val,
                           input logic [WIDTH-1:0] exp_flags);
      req = '0;
      set_req(r, idx, val);
      step();
      chk("wr_gnt", 32'(gnt), 32'(NREQ'(1) << r));
      chk_flags("wr_flags", exp_flags);
      req = '0;
      step();
      chk("wr_gnt_off", 32'(gnt), 0);
   endtask

   initial begin
      int n;
      // Reset state
      #2;
      chk("rst_flags", 32'(flags), 0);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_busy", 32'(busy), 0);
      do_reset();

      // 1: single write
      set_req(0, 3'd0, 1'b1);
      step();
      chk("t1_gnt", 32'(gnt), 32'b001);
      chk_flags("t1_flags", 6'b000001);
      chk("t1_err", 32'(err), 0);
      req = '0;
      step();
      chk("t1_gnt_off", 32'(gnt), 0);

      // 2: three held requests from rr_ptr=0
      do_reset();
      set_req(0, 3'd1, 1'b1);
      set_req(1, 3'd2, 1'b1);
      set_req(2, 3'd3, 1'b1);
      step();
      chk("t2_gnt0", 32'(gnt), 32'b001);
      req = req & ~gnt;
      step();
      chk("t2_gnt1", 32'(gnt), 32'b010);
      req = req & ~gnt;
      step();
      chk("t2_gnt2", 32'(gnt), 32'b100);
      chk_flags("t2_flags", 6'b001110);
      req = req & ~gnt;
      step();
      chk("t2_gnt_off", 32'(gnt), 0);

      // 3: fill then sweep LSB-first
      do_write(0, 3'd0, 1'b1, 6'b001111);
      do_write(0, 3'd4, 1'b1, 6'b011111);
      do_write(0, 3'd5, 1'b1, 6'b111111);
      clr_all = 1'b1;
      step();
      clr_all = 1'b0;
      chk("t3_busy_entry", 32'(busy), 1);
      chk_flags("t3_flags_entry", 6'b111111);
      for (int k = 0; k < WIDTH; k++) begin
         step();
         chk_flags("t3_sweep_flags", 6'(6'b111111 << (k + 1)));
         chk("t3_sweep_busy", 32'(busy), (k < WIDTH - 1) ? 1 : 0);
      end

      // 4: request raised mid-sweep waits for IDLE
      clr_all = 1'b1;
      step();
      clr_all = 1'b0;
      step();
      step();
      set_req(1, 3'd0, 1'b1);
      n = 0;
      while (busy && n < 20) begin
         chk("t4_no_gnt_busy", 32'(gnt), 0);
         step();
         n++;
      end
      if (n >= 20) chk("t4_busy_timeout", 1, 0);
      chk("t4_idle_gnt", 32'(gnt), 0);
      step();
      chk("t4_gnt", 32'(gnt), 32'b010);
      chk_flags("t4_flags", 6'b000001);
      req = '0;
      step();

      // 5: out-of-range index
      set_req(2, 3'd7, 1'b1);
      step();
      chk("t5_gnt", 32'(gnt), 32'b100);
      chk("t5_err", 32'(err), 1);
      chk_flags("t5_flags", 6'b000001);
      req = '0;
      step();
      chk("t5_err_off", 32'(err), 0);
      chk("t5_gnt_off", 32'(gnt), 0);

      // 6: reset mid-sweep at sweep_idx=3 (rr_ptr=1 before reset)
      do_write(0, 3'd5, 1'b1, 6'b100001);
      clr_all = 1'b1;
      step();
      clr_all = 1'b0;
      step();
      step();
      step();
      chk_flags("t6_mid_flags", 6'b100000);
      chk("t6_mid_busy", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_flags("t6_rst_flags", 6'b000000);
      chk("t6_rst_busy", 32'(busy), 0);
      #2;
      rst_n = 1'b1;
      step();
      // rr_ptr back at 0: requester 0 wins first. Same idx: last write wins.
      set_req(0, 3'd4, 1'b1);
      set_req(1, 3'd4, 1'b0);
      step();
      chk("t6_gnt0", 32'(gnt), 32'b001);
      chk_flags("t6_flags0", 6'b010000);
      req = req & ~gnt;
      step();
      chk("t6_gnt1", 32'(gnt), 32'b010);
      chk_flags("t6_flags1", 6'b000000);
      req = req & ~gnt;
      step();
      chk("t6_gnt_off", 32'(gnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
